wb_write_ctrl: RTL and testbench
================================

# wb_write_ctrl

Writeback-side initiator for the 32x128 register file write port. It accepts results from the execute stage over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It converts each result's PPP/WW participation fields into the 16-bit byte-write-enable mask and drives exactly one register-file write per cycle (wren/wraddr/wrdata/wrbyteen). It also exports a 32-bit pending-write scoreboard to decode for hazard checks.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16.
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  execute result valid.
- in_ready  out  1  block can accept this cycle.
- in_addr  in  5  destination register.
- in_data  in  [0:127]  result; byte k = in_data[8k:8k+7].
- in_ppp  in  3  participation: 000 a, 001 u, 010 d, 011 e, 100 o, 101-111 reserved.
- in_ww  in  2  element width: 00 b, 01 h, 10 w, 11 d.
- wr_hold  in  1  write port borrowed by another master; no issue this cycle.
- wren  out  1  register-file write enable, active-high.
- wraddr  out  5  write address.
- wrdata  out  [0:127]  write data, passed unmodified.
- wrbyteen  out  16  bit k enables byte k (wrdata[8k:8k+7]).
- pending  out  32  bit r = a write to register r is queued or on the port.

## Operation
- Accept: a transfer occurs when in_valid && in_ready at posedge. The entry stores addr, data and the computed byte mask.
- in_ready = rst_n && (count < DEPTH), from registered count only. A simultaneous pop does not raise ready when full.
- Mask generation:
  - a → ffff; u → 00ff (bytes 0-7, bits 0:63); d → ff00.
  - e by WW: b → 5555, h → 3333, w → 0f0f, d → 00ff.
  - o: bitwise complement of the e mask for the same WW.
- Reserved PPP: the transfer is accepted and consumed. No entry is stored, pending is not set, and no write is issued.
- Issue: at each posedge, if FIFO non-empty and wr_hold==0, pop the head into the output register with wren=1. Otherwise wren=0 and the FIFO head stays.
- When wren=0, wraddr, wrdata and wrbyteen are driven 0.
- In-order: writes issue in acceptance order. Back-to-back writes to the same address are both issued; neither is merged.
- pending[r] = OR of (valid FIFO entry addr==r) and (wren && wraddr==r), combinational from registered state.
- Simultaneous push and pop in the same cycle: count unchanged. The pushed entry goes to the tail.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH (log2(DEPTH)+1 bits).

## Timing
- Reset (rst_n low, async): FIFO emptied, count=0, wren=0, wraddr=0, wrdata=0, wrbyteen=0, pending=0, in_ready=0.
- After rst_n rises: in_ready=1 in the first cycle.
- Reset mid-operation discards all queued entries. A write on the port is cut immediately (wren drops asynchronously).
- Latency: a result accepted at edge N with an empty FIFO and wr_hold low at edge N+1 gives wren=1 in cycle N+1..N+2. The register file commits it at edge N+2.
- Throughput: one write per cycle while wr_hold is low.
- pending is set in the cycle after acceptance. It clears in the cycle after the last write to that register leaves the port.
- wr_hold is sampled at posedge. Holding for H cycles delays every queued write by exactly H cycles.

## Configuration
- WB_ZERO_R0_EN defined:
  - Entries with in_addr==0 are accepted and consumed but never stored.
  - Such entries never assert wren and never set pending[0]; r0 is never written.
- WB_ZERO_R0_EN undefined: r0 is an ordinary register.

## Test plan
- Reset: assert rst_n=0 mid-stream with 3 entries queued → wren=0 and pending=0 at once. After release, in_ready=1 and no stale write appears.
- Masks:
  - addr 5, ppp a → wrbyteen=ffff.
  - ppp u → 00ff; ppp d → ff00.
  - ppp e, ww=h → 3333; ppp o, ww=w → f0f0.
  - Each with wraddr=5 and wrdata equal to in_data.
- Backpressure: hold wr_hold=1 and push 5 entries, DEPTH=4 → 4 accepted, in_ready=0 on the 5th. Release → 4 consecutive wren cycles in order, then in_ready=1.
- Simultaneous push/pop at count=2 for 10 cycles → count stays 2, write order preserved.
- Scoreboard: two writes to r7 queued → pending[7] stays 1 until the cycle after the second wren, then 0.
- Reserved and r0:
  - ppp=101 → no wren, no pending.
  - addr 0 with WB_ZERO_R0_EN → no wren, pending[0]=0.
  - addr 0 without the macro → wren=1, wraddr=0.

Source files
------------

// File: rtl/wb_write_ctrl_if.sv
// Execute-to-writeback handshake plus the register-file write port and
// pending-write scoreboard, bundled for wb_write_ctrl.
interface wb_write_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   in_addr;
    logic [0:127] in_data;
    logic [2:0]   in_ppp;
    logic [1:0]   in_ww;
    logic         wr_hold;
    logic         wren;
    logic [4:0]   wraddr;
    logic [0:127] wrdata;
    logic [15:0]  wrbyteen;
    logic [31:0]  pending;

    modport slave (
        input  in_valid, in_addr, in_data, in_ppp, in_ww, wr_hold,
        output in_ready, wren, wraddr, wrdata, wrbyteen, pending
    );

    modport master (
        output in_valid, in_addr, in_data, in_ppp, in_ww, wr_hold,
        input  in_ready, wren, wraddr, wrdata, wrbyteen, pending
    );
endinterface

// File: rtl/wb_write_ctrl.sv
// Writeback initiator: buffers execute results, builds byte-write masks and
// issues one register-file write per cycle. WB_ZERO_R0_EN drops writes to r0.
module wb_write_ctrl #(
    parameter int DEPTH = 4
) (
    input logic          clk,
    input logic          rst_n,
    wb_write_ctrl_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [4:0]       fifo_addr [DEPTH];
    logic [0:127]     fifo_data [DEPTH];
    logic [15:0]      fifo_mask [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic             wren_q;
    logic [4:0]       wraddr_q;
    logic [0:127]     wrdata_q;
    logic [15:0]      wrbyteen_q;

    logic             accept;
    logic             drop;
    logic             push;
    logic             pop;
    logic [15:0]      in_mask;
    logic [31:0]      pending_c;
    logic [PTR_W-1:0] scan_idx;

    // Odd-element mask is the complement of the even-element one for the same width.
    function automatic logic [15:0] mask_for(input logic [2:0] ppp, input logic [1:0] ww);
        logic [15:0] even_mask;
        case (ww)
            2'b00:   even_mask = 16'h5555;
            2'b01:   even_mask = 16'h3333;
            2'b10:   even_mask = 16'h0f0f;
            default: even_mask = 16'h00ff;
        endcase
        case (ppp)
            3'b000:  mask_for = 16'hffff;
            3'b001:  mask_for = 16'h00ff;
            3'b010:  mask_for = 16'hff00;
            3'b011:  mask_for = even_mask;
            3'b100:  mask_for = ~even_mask;
            default: mask_for = 16'h0000;
        endcase
    endfunction

    assign bus.in_ready = rst_n && (count < CNT_W'(DEPTH));
    assign accept       = bus.in_valid && bus.in_ready;
    assign in_mask      = mask_for(bus.in_ppp, bus.in_ww);

`ifdef WB_ZERO_R0_EN
    assign drop = (bus.in_ppp > 3'd4) || (bus.in_addr == 5'd0);
`else
    assign drop = (bus.in_ppp > 3'd4);
`endif

    // Dropped results still complete the handshake; they just never occupy a slot.
    assign push = accept && !drop;
    assign pop  = (count != '0) && !bus.wr_hold;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.in_addr;
            fifo_data[wr_ptr] <= bus.in_data;
            fifo_mask[wr_ptr] <= in_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wren_q     <= 1'b0;
            wraddr_q   <= '0;
            wrdata_q   <= '0;
            wrbyteen_q <= '0;
        end else if (pop) begin
            wren_q     <= 1'b1;
            wraddr_q   <= fifo_addr[rd_ptr];
            wrdata_q   <= fifo_data[rd_ptr];
            wrbyteen_q <= fifo_mask[rd_ptr];
        end else begin
            wren_q     <= 1'b0;
            wraddr_q   <= '0;
            wrdata_q   <= '0;
            wrbyteen_q <= '0;
        end
    end

    // Occupied slots are the first `count` entries starting at the read pointer.
    always_comb begin
        pending_c = '0;
        scan_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr + PTR_W'(i);
            if (CNT_W'(i) < count) pending_c[fifo_addr[scan_idx]] = 1'b1;
        end
        if (wren_q) pending_c[wraddr_q] = 1'b1;
    end

    assign bus.wren     = wren_q;
    assign bus.wraddr   = wraddr_q;
    assign bus.wrdata   = wrdata_q;
    assign bus.wrbyteen = wrbyteen_q;
    assign bus.pending  = pending_c;
endmodule

// File: tb/tb_wb_write_ctrl.sv
// Scoreboard bench for wb_write_ctrl: accepted results are modelled as expected
// writes in a queue; a negedge monitor checks wren timing, write contents and pending.
module tb_wb_write_ctrl;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]   addr;
        logic [0:127] data;
        logic [15:0]  mask;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    wb_write_ctrl_if bus();

    wb_write_ctrl #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    wr_t          exp_q[$];
    int           pend_accept = 0;
    logic         exp_wren = 1'b0;
    int           tests = 0;
    int           fails = 0;
    logic [31:0]  mon_pend;
    wr_t          mon_e;

    // Byte k belongs to element k/size; even elements form the 'e' pattern.
    function automatic logic [15:0] model_mask(input logic [2:0] ppp, input logic [1:0] ww);
        int esize;
        logic [15:0] m;
        bit en;
        esize = 1 << ww;
        m = '0;
        for (int k = 0; k < 16; k++) begin
            case (ppp)
                3'd0:    en = 1'b1;
                3'd1:    en = (k < 8);
                3'd2:    en = (k >= 8);
                3'd3:    en = ((k / esize) % 2) == 0;
                3'd4:    en = ((k / esize) % 2) == 1;
                default: en = 1'b0;
            endcase
            m[k] = en;
        end
        return m;
    endfunction

    function automatic bit model_stores(input logic [4:0] addr, input logic [2:0] ppp);
        if (ppp > 3'd4) return 1'b0;
`ifdef WB_ZERO_R0_EN
        if (addr == 5'd0) return 1'b0;
`endif
        return 1'b1;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model of the write port: a write issues at a posedge when a result
    // accepted at an earlier edge is waiting and wr_hold is low.
    always @(posedge clk) begin
        if (!rst_n) exp_wren = 1'b0;
        else        exp_wren = ((exp_q.size() - pend_accept) > 0) && !bus.wr_hold;
        pend_accept = 0;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            mon_pend = '0;
            foreach (exp_q[i]) mon_pend[exp_q[i].addr] = 1'b1;
            checkOutput("pending", bus.pending, mon_pend);
            checkOutput("wren", bus.wren, exp_wren);
            if (exp_wren && exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                checkOutput("wraddr", bus.wraddr, mon_e.addr);
                checkOutput("wrdata", bus.wrdata, mon_e.data);
                checkOutput("wrbyteen", bus.wrbyteen, mon_e.mask);
            end else if (!exp_wren) begin
                checkOutput("idle_outputs_zero", {bus.wraddr, bus.wrbyteen}, '0);
                checkOutput("idle_wrdata_zero", bus.wrdata, '0);
            end
        end
    end

    task automatic applyStimulus(input logic [4:0] addr, input logic [0:127] data,
                                 input logic [2:0] ppp, input logic [1:0] ww, input logic hold);
        int waited;
        wr_t e;
        @(negedge clk);
        bus.wr_hold  = hold;
        bus.in_valid = 1'b1;
        bus.in_addr  = addr;
        bus.in_data  = data;
        bus.in_ppp   = ppp;
        bus.in_ww    = ww;
        #1;
        waited = 0;
        while (!bus.in_ready && waited < 50) begin
            bus.wr_hold = 1'b0;
            @(negedge clk);
            #1;
            waited++;
        end
        checkOutput("accept_within_bound", bus.in_ready, 1'b1);
        if (bus.in_ready && model_stores(addr, ppp)) begin
            e.addr = addr;
            e.data = data;
            e.mask = model_mask(ppp, ww);
            exp_q.push_back(e);
            pend_accept = 1;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int cycles;
        cycles = 0;
        while ((exp_q.size() != 0 || pend_accept != 0) && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("drain_within_bound", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [0:127] rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_addr  = '0;
        bus.in_data  = '0;
        bus.in_ppp   = '0;
        bus.in_ww    = '0;
        bus.wr_hold  = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_wren", bus.wren, 1'b0);
        checkOutput("reset_pending", bus.pending, '0);
        checkOutput("reset_in_ready", bus.in_ready, 1'b0);
        rst_n = 1'b1;
        #1;
        checkOutput("ready_after_reset", bus.in_ready, 1'b1);

        // Mask table at r5
        applyStimulus(5'd5, rand_data(), 3'd0, 2'd0, 1'b0);
        applyStimulus(5'd5, rand_data(), 3'd1, 2'd2, 1'b0);
        applyStimulus(5'd5, rand_data(), 3'd2, 2'd1, 1'b0);
        applyStimulus(5'd5, rand_data(), 3'd3, 2'd1, 1'b0);
        applyStimulus(5'd5, rand_data(), 3'd4, 2'd2, 1'b0);
        applyStimulus(5'd5, rand_data(), 3'd3, 2'd0, 1'b0);
        applyStimulus(5'd5, rand_data(), 3'd4, 2'd3, 1'b0);
        wait_drain();

        // Backpressure: fill while held, fifth must be refused
        for (int i = 0; i < DEPTH; i++) applyStimulus(5'(10 + i), rand_data(), 3'd0, 2'd0, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_addr  = 5'd20;
        #1;
        checkOutput("full_in_ready", bus.in_ready, 1'b0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.wr_hold = 1'b0;
        wait_drain();
        checkOutput("ready_after_drain", bus.in_ready, 1'b1);

        // Steady push/pop at two entries deep
        for (int i = 0; i < 2; i++) applyStimulus(5'(i + 1), rand_data(), 3'd1, 2'd0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(5'($urandom_range(0, 31)), rand_data(), 3'd0, 2'd0, 1'b0);
            checkOutput("steady_in_ready", bus.in_ready, 1'b1);
        end
        wait_drain();

        // Two writes to r7, reserved ppp, and r0
        applyStimulus(5'd7, rand_data(), 3'd0, 2'd0, 1'b1);
        applyStimulus(5'd7, rand_data(), 3'd2, 2'd0, 1'b1);
        repeat (3) @(negedge clk);
        bus.wr_hold = 1'b0;
        wait_drain();
        applyStimulus(5'd9, rand_data(), 3'd5, 2'd0, 1'b0);
        applyStimulus(5'd9, rand_data(), 3'd7, 2'd1, 1'b0);
        applyStimulus(5'd0, rand_data(), 3'd0, 2'd0, 1'b0);
        wait_drain();

        // Reset mid-stream with writes queued and one on the port
        for (int i = 0; i < 3; i++) applyStimulus(5'(3 + i), rand_data(), 3'd0, 2'd0, 1'b1);
        @(negedge clk);
        bus.wr_hold = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("pre_reset_wren", bus.wren, 1'b1);
        rst_n = 1'b0;
        exp_q.delete();
        pend_accept = 0;
        exp_wren = 1'b0;
        #1;
        checkOutput("async_reset_wren", bus.wren, 1'b0);
        checkOutput("async_reset_pending", bus.pending, '0);
        checkOutput("async_reset_in_ready", bus.in_ready, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("ready_after_midreset", bus.in_ready, 1'b1);
        repeat (4) @(negedge clk);

        // Randomized traffic with random holds and gaps
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                bus.wr_hold = ($urandom_range(0, 1) == 0);
            end
            applyStimulus($urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31)),
                          rand_data(), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                          $urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        bus.wr_hold = 1'b0;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
